// File: rtl/word_orient_sequencer.sv
// word_orient_sequencer: assembles N-digit DNA codewords, classifies the 2-digit suffix,
// and emits the oriented payload with reverse/prefix flags and a saturating prefix-error count.
`default_nettype none

module word_orient_sequencer #(
  parameter int N  = 6,
  parameter int CW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        in_digit,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_clear,
  output logic [2*(N-2)-1:0] word_out,
  output logic              reverse_needed,
  output logic              in_prefix,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     prefix_err_cnt
);

  localparam int CNTW = $clog2(N);
  localparam int PW   = 2 * (N - 2);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_CHECK   = 2'd1;
  localparam logic [1:0] S_EMIT    = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_next_state;
  logic [CNTW-1:0] r_cnt;
  logic [2*N-1:0]  r_buf;
  logic            w_take;
  logic            w_last;
  logic            w_hs;
  logic            w_rev;
  logic            w_pre;
  logic [3:0]      w_suffix;
  logic [PW-1:0]   w_payload;
  logic [PW-1:0]   w_payload_rev;

  // Digits shift in at the bottom, so the first digit ends up in the top pair (position N-1).
  assign w_payload = r_buf[2*N-1:4];
  assign w_suffix  = r_buf[3:0];
  assign w_take    = (r_state == S_COLLECT) && in_valid && !in_clear;
  assign w_last    = w_take && (r_cnt == CNTW'(N - 1));
  assign w_hs      = (r_state == S_EMIT) && out_ready;

  generate
    for (genvar gi = 0; gi < N - 2; gi++) begin : g_rev
      assign w_payload_rev[2*gi+1:2*gi] = w_payload[PW-1-2*gi -: 2];
    end
  endgenerate

  always_comb begin
    w_rev = 1'b1;
    w_pre = 1'b1;
    if (w_suffix == 4'b0100) begin
      w_rev = 1'b0;
      w_pre = 1'b0;
    end else if ((w_suffix[3:2] == 2'b01) || (w_suffix[3:2] == 2'b00)) begin
      w_rev = 1'b0;
      w_pre = 1'b1;
    end else if (w_suffix == 4'b1011) begin
      w_rev = 1'b1;
      w_pre = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_COLLECT: if (w_last) w_next_state = S_CHECK;
      S_CHECK:   w_next_state = S_EMIT;
      S_EMIT:    if (out_ready) w_next_state = S_COLLECT;
      default:   w_next_state = S_COLLECT;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_COLLECT: in_ready  = 1'b1;
      S_EMIT:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt          <= '0;
      r_buf          <= '0;
      word_out       <= '0;
      reverse_needed <= 1'b0;
      in_prefix      <= 1'b0;
      prefix_err_cnt <= '0;
    end else begin
      if (r_state == S_COLLECT) begin
        if (in_clear) begin
          r_cnt <= '0;
        end else if (w_take) begin
          r_buf <= {r_buf[2*N-3:0], in_digit};
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
      end
      if (r_state == S_CHECK) begin
        word_out       <= w_rev ? w_payload_rev : w_payload;
        reverse_needed <= w_rev;
        in_prefix      <= w_pre;
      end
      if (w_hs && in_prefix && (prefix_err_cnt != {CW{1'b1}})) begin
        prefix_err_cnt <= prefix_err_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_word_orient_sequencer.sv
// Directed bench for word_orient_sequencer: two instances (CW=8, CW=2) share one stimulus stream.
`default_nettype none

module tb_word_orient_sequencer;

  logic       clk;
  logic       rst_n;
  logic [1:0] in_digit;
  logic       in_valid;
  logic       in_clear;
  logic       out_ready;
  logic       in_ready, in_ready2;
  logic [7:0] word_out, word_out2;
  logic       reverse_needed, reverse_needed2;
  logic       in_prefix, in_prefix2;
  logic       out_valid, out_valid2;
  logic [7:0] prefix_err_cnt;
  logic [1:0] prefix_err_cnt2;

  int n_checks = 0;
  int n_err    = 0;

  word_orient_sequencer #(.N(6), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_digit(in_digit), .in_valid(in_valid),
    .in_ready(in_ready), .in_clear(in_clear), .word_out(word_out),
    .reverse_needed(reverse_needed), .in_prefix(in_prefix), .out_valid(out_valid),
    .out_ready(out_ready), .prefix_err_cnt(prefix_err_cnt)
  );

  word_orient_sequencer #(.N(6), .CW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_digit(in_digit), .in_valid(in_valid),
    .in_ready(in_ready2), .in_clear(in_clear), .word_out(word_out2),
    .reverse_needed(reverse_needed2), .in_prefix(in_prefix2), .out_valid(out_valid2),
    .out_ready(out_ready), .prefix_err_cnt(prefix_err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word given as 12 bits, first digit in the top pair; returns at the negedge after the last accept.
  task automatic send_word(input logic [11:0] w);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_digit = w[11-2*i -: 2];
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_digit = 2'b00;
  endtask

  task automatic run_word(input string tag, input logic [11:0] w, input logic [7:0] ew,
                          input logic er, input logic ep, input int c1, input int c2);
    send_word(w);
    chk({tag, "_check_ov"}, 32'(out_valid), 32'd0);
    chk({tag, "_check_ir"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    chk({tag, "_ov"}, 32'(out_valid), 32'd1);
    chk({tag, "_word"}, 32'(word_out), 32'(ew));
    chk({tag, "_rev"}, 32'(reverse_needed), 32'(er));
    chk({tag, "_pre"}, 32'(in_prefix), 32'(ep));
    @(negedge clk);
    chk({tag, "_ir_after"}, 32'(in_ready), 32'd1);
    chk({tag, "_cnt"}, 32'(prefix_err_cnt), 32'(c1));
    chk({tag, "_cnt2"}, 32'(prefix_err_cnt2), 32'(c2));
  endtask

  localparam logic [11:0] W1 = 12'b01_10_11_00_01_00;
  localparam logic [11:0] W2 = 12'b01_10_11_00_10_11;
  localparam logic [11:0] W3 = 12'b01_10_11_00_00_10;
  localparam logic [11:0] W4 = 12'b01_10_11_00_11_01;

  initial begin
    rst_n     = 1'b0;
    in_digit  = 2'b00;
    in_valid  = 1'b0;
    in_clear  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ir", 32'(in_ready), 32'd1);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_word", 32'(word_out), 32'd0);
    chk("rst_flags", {30'd0, reverse_needed, in_prefix}, 32'd0);
    chk("rst_cnt", 32'(prefix_err_cnt), 32'd0);

    run_word("fwd", W1, 8'b01101100, 1'b0, 1'b0, 0, 0);
    run_word("rev", W2, 8'b00111001, 1'b1, 1'b0, 0, 0);
    run_word("pre_fwd", W3, 8'b01101100, 1'b0, 1'b1, 1, 1);
    run_word("pre_rev", W4, 8'b00111001, 1'b1, 1'b1, 2, 2);

    // Backpressure: hold EMIT for 5 cycles while a digit is offered on the input.
    out_ready = 1'b0;
    send_word(W1);
    @(negedge clk);
    in_valid = 1'b1;
    in_digit = 2'b11;
    for (int i = 0; i < 5; i++) begin
      chk("stall_ov", 32'(out_valid), 32'd1);
      chk("stall_ir", 32'(in_ready), 32'd0);
      chk("stall_word", 32'(word_out), 32'h6C);
      chk("stall_flags", {30'd0, reverse_needed, in_prefix}, 32'd0);
      chk("stall_cnt", 32'(prefix_err_cnt), 32'd2);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("stall_release_ov", 32'(out_valid), 32'd0);
    run_word("after_stall", W1, 8'b01101100, 1'b0, 1'b0, 2, 2);

    // Partial word, then clear with a simultaneous valid digit that must be dropped.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_digit = 2'b01;
    end
    @(negedge clk);
    in_clear = 1'b1;
    in_valid = 1'b1;
    in_digit = 2'b11;
    @(negedge clk);
    in_clear = 1'b0;
    in_valid = 1'b0;
    run_word("after_clear", W2, 8'b00111001, 1'b1, 1'b0, 2, 2);

    // Reset pulse while a prefix-flagged word is held in EMIT.
    out_ready = 1'b0;
    send_word(W3);
    @(negedge clk);
    chk("pre_reset_ov", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ov", 32'(out_valid), 32'd0);
    chk("async_rst_cnt", 32'(prefix_err_cnt), 32'd0);
    chk("async_rst_word", 32'(word_out), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;

    run_word("sat1", W3, 8'b01101100, 1'b0, 1'b1, 1, 1);
    run_word("sat2", W3, 8'b01101100, 1'b0, 1'b1, 2, 2);
    run_word("sat3", W3, 8'b01101100, 1'b0, 1'b1, 3, 3);
    run_word("sat4", W3, 8'b01101100, 1'b0, 1'b1, 4, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/word_orient_sequencer.md
WORD_ORIENT_SEQUENCER -- requirements
Module: word_orient_sequencer

Interface
REQ-001 SHALL have parameter N, default 6: digits per codeword including the 2-digit suffix; legal range 5..16.
REQ-002 SHALL have parameter CW, default 8: width of the prefix-error counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_digit, input, 2: DNA digit (00=4, 01=1, 10=2, 11=3).
REQ-006 SHALL have port in_valid, input, 1: in_digit is valid.
REQ-007 SHALL have port in_ready, output, 1: block accepts a digit this cycle.
REQ-008 SHALL have port in_clear, input, 1: discard the partially assembled word.
REQ-009 SHALL have port word_out, output, 2*(N-2): payload digits, oriented.
REQ-010 SHALL have port reverse_needed, output, 1: payload was digit-reversed.
REQ-011 SHALL have port in_prefix, output, 1: deletion located in the prefix.
REQ-012 SHALL have port out_valid, output, 1: word_out and flags are valid.
REQ-013 SHALL have port out_ready, input, 1: consumer accepts the output word.
REQ-014 SHALL have port prefix_err_cnt, output, CW: saturating count of emitted words with in_prefix=1.

Function
REQ-015 SHALL implement the FSM states COLLECT, CHECK and EMIT.
REQ-016 COLLECT: in_ready=1; a digit transfers when in_valid&&in_ready; the first digit of a word fills position N-1, the last fills position 0.
REQ-017 COLLECT: the digit counter runs 0..N-1; the transfer at count N-1 SHALL move the FSM to CHECK and reset the count to 0.
REQ-018 in_clear in COLLECT SHALL zero the count next cycle and drop any digit presented in the same cycle; in_clear SHALL win over in_valid.
REQ-019 in_clear in CHECK or EMIT SHALL be ignored.
REQ-020 CHECK lasts exactly 1 cycle with in_ready=0; it SHALL classify on the suffix S={pos1,pos0} in priority order:
- S==0100 -> reverse=0, prefix=0.
- else pos1 in {01,00} -> reverse=0, prefix=1.
- else S==1011 -> reverse=1, prefix=0.
- else -> reverse=1, prefix=1.
REQ-021 CHECK SHALL register word_out = positions N-1..2 in received order if reverse=0, or with digit order reversed if reverse=1 (bit pairs swapped, not bits); it SHALL then go to EMIT.
REQ-022 EMIT: out_valid=1; word_out and both flags SHALL hold stable until out_valid&&out_ready.
REQ-023 On the EMIT handshake the FSM SHALL return to COLLECT, and prefix_err_cnt SHALL increment if in_prefix=1, saturating at 2^CW-1.
REQ-024 Latency: last digit accepted in cycle t -> CHECK in t+1 -> out_valid=1 in t+2.
REQ-025 Minimum word period SHALL be N+2 cycles with out_ready tied to 1.
REQ-026 in_ready SHALL be 0 in CHECK and EMIT; no digit SHALL be accepted while a word is pending.
REQ-027 All outputs SHALL be registered; in_ready and out_valid SHALL be decoded from state only.

Reset
REQ-028 rst_n=0 SHALL immediately force: state=COLLECT, count=0, word_out=0, reverse_needed=0, in_prefix=0, out_valid=0, prefix_err_cnt=0; in_ready=1 after reset release.
REQ-029 Reset asserted mid-word or during EMIT SHALL discard the word with no output handshake; the first digit after release is position N-1.

Verification
REQ-030 N=6, digits 1,2,3,4,1,4 (01,10,11,00,01,00), out_ready=1 -> out_valid in t+2; word_out=01101100, reverse_needed=0, in_prefix=0, counter unchanged.
REQ-031 N=6, digits 1,2,3,4,2,3 -> word_out=00111001, reverse_needed=1, in_prefix=0.
REQ-032 N=6, suffix digits 4,2 (00,10) -> reverse_needed=0, in_prefix=1, prefix_err_cnt +1 on handshake; suffix 3,1 (11,01) -> reverse_needed=1, in_prefix=1.
REQ-033 out_ready=0 for 5 cycles in EMIT -> out_valid, word_out and flags stable, in_ready=0, counter unchanged; the input stream stalls until the handshake.
REQ-034 in_clear with in_valid after 3 digits -> that digit dropped; the next 6 digits form a clean word; rst_n pulse during EMIT -> out_valid=0 asynchronously, counter=0.
REQ-035 CW=2, 4 prefix-flagged words -> prefix_err_cnt reads 1,2,3,3 (saturated).
